// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Stall/flush sequencer placed directly after the hazard detection unit.
// It turns hazard and control-flow events into write enables and bubble/flush
// controls for the PC, IF/ID and ID/EX registers. Multi-cycle waits for a PC
// redirect are tracked by a small FSM. Stall cycles are counted for
// performance monitoring and deadlock detection.
//
// Optional feature macro: STALL_WATCHDOG_EN
//   When defined, a consecutive-stall count reaching WDOG_LIMIT while in
//   DSTALL or PCWAIT sets the sticky wdog_err and forces the FSM back to RUN.
//   The cycle after that is a flush cycle. When undefined, wdog_err is tied low.
//
// Ports
//   clk           in   system clock; all state changes on the rising edge
//   rst_n         in   asynchronous active-low reset
//   data_hazard   in   register source not yet written back
//   PC_hazard     in   return target pending
//   PC_update     in   redirect target computed this cycle (held until pc_en)
//   branch_taken  in   branch resolved taken in EX
//   halt          in   HLT decoded in ID
//   pc_en         out  PC register write enable
//   ifid_en       out  IF/ID register write enable
//   ifid_flush    out  clear IF/ID to NOP on the next edge
//   idex_bubble   out  load NOP into ID/EX on the next edge
//   halted        out  core halted (sticky until reset)
//   stall_cnt     out  consecutive stall cycles, saturating
//   stall_total   out  total stall cycles since reset, saturating
//   wdog_err      out  watchdog tripped, sticky
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int CNT_W      = 8,
    parameter int PERF_W     = 16,
    parameter int WDOG_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_hazard,
    input  logic              PC_hazard,
    input  logic              PC_update,
    input  logic              branch_taken,
    input  logic              halt,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [PERF_W-1:0] stall_total,
    output logic              wdog_err
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DSTALL = 3'd1,
        PCWAIT = 3'd2,
        FLUSH  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              pc_en_raw;
    logic              ifid_en_raw;
    logic              flush_raw;
    logic              bubble_raw;
    logic              stall_inc;
    logic [CNT_W-1:0]  stall_cnt_nxt;
    logic [PERF_W-1:0] stall_total_nxt;
    logic              wdog_trip;
    logic              wdog_kick;

    // Reject a watchdog limit the consecutive-stall counter can never reach.
    if (WDOG_LIMIT < 1 || WDOG_LIMIT >= (1 << CNT_W)) begin : g_bad_wdog_limit
        $error("pipe_stall_ctrl: WDOG_LIMIT must lie in 1 .. 2**CNT_W-1");
    end

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc_perf(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

    // Next state and raw controls; the enables react to hazards in the same
    // cycle, so everything here is combinational from state and inputs.
    always_comb begin
        state_nxt   = state;
        pc_en_raw   = 1'b1;
        ifid_en_raw = 1'b1;
        flush_raw   = 1'b0;
        bubble_raw  = 1'b0;
        case (state)
            RUN, DSTALL: begin
                if (wdog_kick) begin
                    // Recovery cycle after a watchdog trip: drop whatever
                    // was stuck in IF/ID and refetch.
                    flush_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    state_nxt  = RUN;
                end else if (halt) begin
                    pc_en_raw   = 1'b0;
                    ifid_en_raw = 1'b0;
                    bubble_raw  = 1'b1;
                    state_nxt   = HALTED;
                end else if (PC_hazard) begin
                    // Any PC_update arriving together with the hazard is
                    // ignored here; the PC logic holds it until pc_en=1.
                    pc_en_raw   = 1'b0;
                    ifid_en_raw = 1'b0;
                    bubble_raw  = 1'b1;
                    state_nxt   = PCWAIT;
                end else if (data_hazard) begin
                    pc_en_raw   = 1'b0;
                    ifid_en_raw = 1'b0;
                    bubble_raw  = 1'b1;
                    state_nxt   = DSTALL;
                end else if (branch_taken) begin
                    flush_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    state_nxt  = FLUSH;
                end else begin
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (halt) begin
                    pc_en_raw   = 1'b0;
                    ifid_en_raw = 1'b0;
                    bubble_raw  = 1'b1;
                    state_nxt   = HALTED;
                end else begin
                    flush_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    state_nxt  = RUN;
                end
            end
            PCWAIT: begin
                if (PC_update) begin
                    flush_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    state_nxt  = RUN;
                end else begin
                    pc_en_raw   = 1'b0;
                    ifid_en_raw = 1'b0;
                    bubble_raw  = 1'b1;
                end
            end
            HALTED: begin
                pc_en_raw   = 1'b0;
                ifid_en_raw = 1'b0;
                bubble_raw  = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // A halted core is not stalling, so HALTED freezes both counters.
    always_comb begin
        stall_inc       = !pc_en_raw && (state != HALTED);
        stall_cnt_nxt   = stall_cnt;
        stall_total_nxt = stall_total;
        if (pc_en_raw) begin
            stall_cnt_nxt = '0;
        end else if (stall_inc) begin
            stall_cnt_nxt = sat_inc_cnt(stall_cnt);
        end
        if (stall_inc) begin
            stall_total_nxt = sat_inc_perf(stall_total);
        end
    end

`ifdef STALL_WATCHDOG_EN
    // Trip on the edge where the consecutive count becomes WDOG_LIMIT.
    assign wdog_trip = stall_inc && (state == DSTALL || state == PCWAIT) &&
                       (stall_cnt_nxt == CNT_W'(WDOG_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_err  <= 1'b0;
            wdog_kick <= 1'b0;
        end else begin
            if (wdog_trip) begin
                wdog_err <= 1'b1;
            end
            wdog_kick <= wdog_trip;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign wdog_kick = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            stall_cnt   <= '0;
            stall_total <= '0;
        end else begin
            state       <= wdog_trip ? RUN : state_nxt;
            stall_cnt   <= stall_cnt_nxt;
            stall_total <= stall_total_nxt;
        end
    end

    // While reset is asserted the pipeline is held with a bubble in ID/EX.
    assign pc_en       = rst_n && pc_en_raw;
    assign ifid_en     = rst_n && ifid_en_raw;
    assign ifid_flush  = rst_n && flush_raw;
    assign idex_bubble = !rst_n || bubble_raw;
    assign halted      = (state == HALTED);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pipe_stall_ctrl. Each cycle the stimulus and the outputs
// expected for that cycle are pushed to a scoreboard; the outputs are sampled
// 2 time units after the falling edge and compared against the popped entry.
// Counter expectations come from a tiny model driven by the expected enables.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    localparam int CNT_W      = 8;
    localparam int PERF_W     = 16;
    localparam int WDOG_LIMIT = 64;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam int PERF_MAX   = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              data_hazard = 1'b0;
    logic              PC_hazard = 1'b0;
    logic              PC_update = 1'b0;
    logic              branch_taken = 1'b0;
    logic              halt = 1'b0;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;
    logic [PERF_W-1:0] stall_total;
    logic              wdog_err;

    pipe_stall_ctrl #(
        .CNT_W      (CNT_W),
        .PERF_W     (PERF_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_hazard  (data_hazard),
        .PC_hazard    (PC_hazard),
        .PC_update    (PC_update),
        .branch_taken (branch_taken),
        .halt         (halt),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .stall_total  (stall_total),
        .wdog_err     (wdog_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              pc_en;
        logic              ifid_en;
        logic              flush;
        logic              bubble;
        logic              halted;
        logic              wdog;
        logic [CNT_W-1:0]  cnt;
        logic [PERF_W-1:0] total;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    m_cnt    = 0;
    int    m_total  = 0;
    logic  exp_wdog = 1'b0;
    string phase    = "init";

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s/%s at %0t: got %0d, expected %0d", phase, tag, $time, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue expectations, sample and compare,
    // then advance the counter model for the coming edge.
    task automatic step(input logic rn, input logic dh, input logic ph, input logic pu,
                        input logic bt, input logic hl,
                        input logic e_pc, input logic e_if, input logic e_fl,
                        input logic e_bub, input logic e_h);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n        = rn;
        data_hazard  = dh;
        PC_hazard    = ph;
        PC_update    = pu;
        branch_taken = bt;
        halt         = hl;
        if (!rn) begin
            m_cnt    = 0;
            m_total  = 0;
            exp_wdog = 1'b0;
        end
        e.pc_en   = e_pc;
        e.ifid_en = e_if;
        e.flush   = e_fl;
        e.bubble  = e_bub;
        e.halted  = e_h;
        e.wdog    = exp_wdog;
        e.cnt     = CNT_W'(m_cnt);
        e.total   = PERF_W'(m_total);
        sb_q.push_back(e);
        #2;
        got = sb_q.pop_front();
        check_val("pc_en",       32'(pc_en),       32'(got.pc_en));
        check_val("ifid_en",     32'(ifid_en),     32'(got.ifid_en));
        check_val("ifid_flush",  32'(ifid_flush),  32'(got.flush));
        check_val("idex_bubble", 32'(idex_bubble), 32'(got.bubble));
        check_val("halted",      32'(halted),      32'(got.halted));
        check_val("wdog_err",    32'(wdog_err),    32'(got.wdog));
        check_val("stall_cnt",   32'(stall_cnt),   32'(got.cnt));
        check_val("stall_total", 32'(stall_total), 32'(got.total));
        if (rn) begin
            if (e_pc) begin
                m_cnt = 0;
            end else if (!e_h) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (m_total < PERF_MAX) m_total++;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs dh, ph, pu, bt, hl; stalled-cycle outputs expected.
    task automatic stall(input logic dh, input logic ph, input logic pu,
                         input logic bt, input logic hl);
        step(1'b1, dh, ph, pu, bt, hl, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Inputs dh, ph, pu, bt, hl; flush-cycle outputs expected.
    task automatic flush(input logic dh, input logic ph, input logic pu,
                         input logic bt, input logic hl);
        step(1'b1, dh, ph, pu, bt, hl, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        phase = "reset";
        do_reset();
        stall(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stall(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        phase = "dstall3";
        do_reset();
        repeat (3) stall(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_val("total_after_3", 32'(stall_total), 32'd3);

        phase = "pcwait5";
        do_reset();
        stall(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) stall(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        flush(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check_val("total_after_pc", 32'(stall_total), 32'd5);

        phase = "pcwait_ignore";
        do_reset();
        stall(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        stall(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        flush(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);

        phase = "priority";
        stall(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        stall(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        flush(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);

        phase = "branch";
        do_reset();
        flush(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        flush(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        check_val("total_after_branch", 32'(stall_total), 32'd0);
        stall(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        flush(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        flush(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        phase = "pcwait_reset";
        stall(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stall(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        phase = "halt";
        do_reset();
        stall(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++)
            step(1'b1, 1'b0, 1'b0, logic'(i % 2), 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        do_reset();
        idle(1);

        phase = "stuck";
        do_reset();
`ifdef STALL_WATCHDOG_EN
        for (int i = 0; i < 140; i++) begin
            logic kick;
            kick = (i == 64) || (i == 129);
            if (i == 64) exp_wdog = 1'b1;
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, kick, kick, kick, 1'b1, 1'b0);
        end
        check_val("wdog_sticky", 32'(wdog_err), 32'd1);
`else
        for (int i = 0; i < 300; i++)
            stall(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("cnt_saturated", 32'(stall_cnt), 32'd255);
        check_val("wdog_idle", 32'(wdog_err), 32'd0);
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
